line_sequencer: RTL and testbench

Animation controller feeding the line drawer. Steps through a fixed table of four line segments. For each segment it issues a draw pass (colour 1), holds for a programmable time, then issues an erase pass (colour 0) over the same endpoints, handshaking with the drawer through a start/done pair. It replaces the free-running counter and combinational endpoint decode in the top level, so the drawer never receives new endpoints mid-line.

---
 rtl/line_sequencer.sv | 115 +++++++++++
 tb/tb_line_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/line_sequencer.sv
// Animation sequencer for the line drawer: draw, hold, then erase each of four segments.
// Optional erase pass enabled by defining LINE_SEQ_ERASE_EN; otherwise lines accumulate.
module line_sequencer #(
  parameter int COORD_W     = 11,
  parameter int HOLD_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               drawer_done,
  output logic               drawer_start,
  output logic [COORD_W-1:0] x0,
  output logic [COORD_W-1:0] y0,
  output logic [COORD_W-1:0] x1,
  output logic [COORD_W-1:0] y1,
  output logic               pixel_color,
  output logic [1:0]         line_index,
  output logic               busy,
  output logic [2:0]         dbg_state
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    SETTLE    = 3'd2,
    WAIT_DONE = 3'd3,
    HOLD      = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       index_q, index_d;
  logic             phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      index_q <= 2'd0;
      phase_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  // drawer_done is only looked at in WAIT_DONE, so a done left high by the
  // previous line cannot end the new one during ISSUE/SETTLE.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = ISSUE;
          phase_d = 1'b0;
        end
      end
      ISSUE:  state_d = SETTLE;
      SETTLE: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (drawer_done) begin
          if (!phase_q) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            index_d = index_q + 2'd1;
            phase_d = 1'b0;
            state_d = enable ? ISSUE : IDLE;
          end
        end
      end
      HOLD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == HOLD_LAST) begin
`ifdef LINE_SEQ_ERASE_EN
          phase_d = 1'b1;
          state_d = ISSUE;
`else
          index_d = index_q + 2'd1;
          state_d = enable ? ISSUE : IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    x0 = COORD_W'(120);
    y0 = COORD_W'(200);
    x1 = COORD_W'(320);
    y1 = COORD_W'(300);
    case (index_q)
      2'd0: begin x0 = COORD_W'(120); y0 = COORD_W'(200); x1 = COORD_W'(320); y1 = COORD_W'(300); end
      2'd1: begin x0 = COORD_W'(320); y0 = COORD_W'(200); x1 = COORD_W'(320); y1 = COORD_W'(300); end
      2'd2: begin x0 = COORD_W'(420); y0 = COORD_W'(200); x1 = COORD_W'(320); y1 = COORD_W'(300); end
      default: begin x0 = COORD_W'(120); y0 = COORD_W'(250); x1 = COORD_W'(420); y1 = COORD_W'(250); end
    endcase
  end

  assign drawer_start = (state_q == ISSUE);
  assign pixel_color  = ~phase_q;
  assign line_index   = index_q;
  assign busy         = (state_q != IDLE);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_line_sequencer.sv
// Bench for line_sequencer: vector tables of expected start pulses checked by a scoreboard.
// Expectations follow the erase/no-erase build selected by LINE_SEQ_ERASE_EN.
module tb_line_sequencer;

  localparam int COORD_W = 11;
  localparam int HOLD    = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic               drawer_done;
  logic               drawer_start;
  logic [COORD_W-1:0] x0, y0, x1, y1;
  logic               pixel_color;
  logic [1:0]         line_index;
  logic               busy;
  logic [2:0]         dbg_state;

  line_sequencer #(.COORD_W(COORD_W), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .enable(enable), .drawer_done(drawer_done),
    .drawer_start(drawer_start), .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .pixel_color(pixel_color), .line_index(line_index), .busy(busy),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // One record per expected start pulse: inputs to apply, then expected pulse.
  typedef struct {
    bit en;       // enable level applied before waiting for the pulse
    bit dh;       // drawer model holds done permanently
    int idx;      // expected line_index
    bit col;      // expected pixel_color
    int gap;      // cycles since previous pulse (or since enable was raised)
    bit from_en;  // gap measured from the cycle enable was raised
  } vec_t;

  int seg_tab [4][4] = '{'{120, 200, 320, 300}, '{320, 200, 320, 300},
                         '{420, 200, 320, 300}, '{120, 250, 420, 250}};

  vec_t exp_q [$];
  vec_t tab_a [$];
  vec_t tab_b [$];
  vec_t mon_e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_cyc = 0;
  int last_start = 0;
  bit prev_start = 1'b0;
  bit done_hi = 1'b0;
  int d_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Drawer model: done rises 3 cycles after the start pulse and stays high until the next start.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      drawer_done <= 1'b0;
      d_cnt <= 0;
    end else if (done_hi) begin
      drawer_done <= 1'b1;
      d_cnt <= 0;
    end else if (drawer_start) begin
      drawer_done <= 1'b0;
      d_cnt <= 1;
    end else if (d_cnt == 1) begin
      d_cnt <= 2;
    end else if (d_cnt == 2) begin
      drawer_done <= 1'b1;
      d_cnt <= 0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(bit en, bit dh, int idx, bit col, int gap, bit from_en);
    vec_t v;
    v.en = en; v.dh = dh; v.idx = idx; v.col = col; v.gap = gap; v.from_en = from_en;
    return v;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (drawer_start) begin
        check("start_width", int'(prev_start), 0);
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_start: got pulse idx %0d color %0d, expected none (cycle %0d)",
                   line_index, pixel_color, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("pulse_idx", int'(line_index), mon_e.idx);
          check("pulse_color", int'(pixel_color), int'(mon_e.col));
          check("pulse_x0", int'(x0), seg_tab[mon_e.idx][0]);
          check("pulse_y0", int'(y0), seg_tab[mon_e.idx][1]);
          check("pulse_x1", int'(x1), seg_tab[mon_e.idx][2]);
          check("pulse_y1", int'(y1), seg_tab[mon_e.idx][3]);
          check("pulse_gap", cyc - (mon_e.from_en ? en_cyc : last_start), mon_e.gap);
        end
        last_start = cyc;
      end
      prev_start = drawer_start;
    end
  end

  task automatic run_vec(input vec_t v);
    enable  = v.en;
    done_hi = v.dh;
    if (v.from_en) en_cyc = cyc;
    exp_q.push_back(v);
    for (int t = 0; t < 40; t++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) break;
    end
    check("pulse_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_rest(input string name, input int idx, input int bsy);
    check({name, "_busy"}, int'(busy), bsy);
    check({name, "_start"}, int'(drawer_start), 0);
    check({name, "_color"}, int'(pixel_color), 1);
    check({name, "_idx"}, int'(line_index), idx);
    check({name, "_x0"}, int'(x0), seg_tab[idx][0]);
    check({name, "_y0"}, int'(y0), seg_tab[idx][1]);
    check({name, "_x1"}, int'(x1), seg_tab[idx][2]);
    check({name, "_y1"}, int'(y1), seg_tab[idx][3]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef LINE_SEQ_ERASE_EN
    tab_a.push_back(mk(1, 0, 0, 1, 1, 1));
    tab_a.push_back(mk(1, 0, 0, 0, 8, 0));
    tab_a.push_back(mk(1, 0, 1, 1, 4, 0));
    tab_a.push_back(mk(1, 0, 1, 0, 8, 0));
    tab_a.push_back(mk(1, 0, 2, 1, 4, 0));
    tab_a.push_back(mk(1, 0, 2, 0, 8, 0));
    tab_a.push_back(mk(1, 0, 3, 1, 4, 0));
    tab_a.push_back(mk(1, 0, 3, 0, 8, 0));
    tab_a.push_back(mk(1, 0, 0, 1, 4, 0));
    tab_a.push_back(mk(1, 0, 0, 0, 8, 0));
    tab_b.push_back(mk(1, 1, 2, 1, 1, 1));
    tab_b.push_back(mk(1, 1, 2, 0, 7, 0));
    tab_b.push_back(mk(1, 1, 3, 1, 3, 0));
    tab_b.push_back(mk(1, 1, 3, 0, 7, 0));
    tab_b.push_back(mk(1, 1, 0, 1, 3, 0));
    tab_b.push_back(mk(1, 0, 0, 0, 8, 0));
    tab_b.push_back(mk(1, 0, 1, 1, 4, 0));
    tab_b.push_back(mk(1, 0, 1, 0, 8, 0));
    tab_b.push_back(mk(1, 0, 2, 1, 4, 0));
`else
    tab_a.push_back(mk(1, 0, 0, 1, 1, 1));
    tab_a.push_back(mk(1, 0, 1, 1, 8, 0));
    tab_a.push_back(mk(1, 0, 2, 1, 8, 0));
    tab_a.push_back(mk(1, 0, 3, 1, 8, 0));
    tab_a.push_back(mk(1, 0, 0, 1, 8, 0));
    tab_b.push_back(mk(1, 1, 2, 1, 1, 1));
    tab_b.push_back(mk(1, 1, 3, 1, 7, 0));
    tab_b.push_back(mk(1, 1, 0, 1, 7, 0));
    tab_b.push_back(mk(1, 0, 1, 1, 8, 0));
    tab_b.push_back(mk(1, 0, 2, 1, 8, 0));
`endif

    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check_rest("in_reset", 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      check("idle_busy", int'(busy), 0);
    end
    check_rest("idle", 0, 0);

    for (int i = 0; i < tab_a.size(); i++) run_vec(tab_a[i]);

    // Drop enable in the HOLD of index 1: the pair for index 1 must still complete.
`ifdef LINE_SEQ_ERASE_EN
    run_vec(mk(1, 0, 1, 1, 4, 0));
    repeat (4) @(negedge clk);
    #1;
    run_vec(mk(0, 0, 1, 0, 8, 0));
`else
    run_vec(mk(1, 0, 1, 1, 8, 0));
    repeat (4) @(negedge clk);
    #1;
    enable = 1'b0;
`endif
    repeat (12) @(negedge clk);
    #1;
    check_rest("after_drop", 2, 0);

    for (int i = 0; i < tab_b.size(); i++) run_vec(tab_b[i]);

    // Index 2 draw just issued: two edges later the sequencer is in WAIT_DONE.
    repeat (2) @(negedge clk);
    reset  = 1'b1;
    enable = 1'b0;
    #1;
    check_rest("mid_reset", 0, 0);
    check("mid_reset_done", int'(drawer_done), 0);
    @(negedge clk);
    reset   = 1'b0;
    done_hi = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check_rest("post_reset", 0, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
